sprite_overlay: RTL
===================

# sprite_overlay

- Per-pixel compositor that sits between the VGA timing generator and the RGB output register.
- Converts screen coordinates into sprite-ROM `row`/`col` addresses and feeds the 1-cycle-latency sprite ROM (e.g. the fill-shape ROMs: 12-bit colour, row-major, SPR_W columns).
- Consumes the ROM's `color_data` and merges it over a background colour with colour-key transparency.
- Latches sprite position once per frame and reports per-frame opaque-pixel statistics.

## Interface
Parameters:
- SPR_W, 584, sprite width in pixels (ROM row stride)
- SPR_H, 167, sprite height in rows
- KEY_COLOR, 12'h000, ROM colour treated as transparent

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount  in  10  current pixel column, 0..639 visible
- vcount  in  10  current pixel row, 0..479 visible
- video_on  in  1  high in visible region
- frame_start  in  1  one-cycle pulse at start of each frame
- pos_x  in  10  requested sprite left edge
- pos_y  in  10  requested sprite top edge
- bg_color  in  12  background colour for this pixel
- rom_row  out  8  sprite ROM row address
- rom_col  out  10  sprite ROM column address
- rom_data  in  12  sprite ROM colour, valid 1 cycle after address
- pix_color  out  12  composited RGB444 pixel
- pix_hit  out  1  high when pix_color came from an opaque sprite pixel
- opaque_cnt  out  17  opaque sprite pixels drawn in previous frame

## Operation
Position latch:
- `x_lat`/`y_lat` load pos_x/pos_y on the `frame_start` cycle.
- Mid-frame changes to pos_x/pos_y are ignored until the next `frame_start`.

Stage 1 (address):
- Compute `in_box` = hcount ≥ x_lat && hcount < x_lat+SPR_W && vcount ≥ y_lat && vcount < y_lat+SPR_H.
- Sums are 11-bit; no overflow.
- In box: rom_col ← hcount−x_lat, rom_row ← vcount−y_lat, truncated to port widths.
- Out of box: rom_row/rom_col ← 0.
- Register sideband alongside the address: in_box, video_on, bg_color.

Stage 2:
- Sideband delayed one more stage, aligned with rom_data.

Stage 3 (output):
- video_on low → pix_color ← 0, pix_hit ← 0.
- Else if in_box and rom_data ≠ KEY_COLOR (and not blinked off) → pix_color ← rom_data, pix_hit ← 1.
- Else → pix_color ← bg_color, pix_hit ← 0.

Statistics:
- 17-bit `acc` counts cycles with pix_hit=1, saturating at 2^17−1.
- On `frame_start`: opaque_cnt ← acc, and acc restarts at 0.
- If pix_hit=1 in the same cycle as `frame_start`, that pixel counts into the new frame: acc ← 1.

Sprite placement:
- Sprites partly off-screen are clipped naturally; only visible pixels are fetched.

## Timing
- Reset values: rom_row/rom_col 0, pix_color 0, pix_hit 0, opaque_cnt 0; x_lat/y_lat/acc/pipeline sideband 0.
- Reset applies asynchronously on rst_n fall; release is synchronous to clk.
- Latency is 3 edges: inputs sampled at edge T produce rom_row/rom_col after T, rom_data after T+1, pix_color/pix_hit after T+2.
- Upstream must advance hsync/vsync by 3 cycles to match.
- `frame_start` affects in_box starting with the pixel sampled one cycle after the pulse.
- Pixels already in the pipeline finish with the old position.
- Throughput: one pixel per cycle; no stalls, no backpressure.
- Reset asserted mid-frame: pipeline contents are discarded and the output is black until 3 cycles after reset release.

## Configuration
- SPRITE_BLINK_EN defined:
  - 6-bit frame counter increments on each `frame_start` and wraps 63→0.
  - While counter bit 5 = 1, sprite pixels are suppressed: background shown, pix_hit=0, acc not incremented.
  - Result is 32 frames shown, 32 hidden; counter resets to 0.
- SPRITE_BLINK_EN undefined:
  - Counter is absent and the sprite is always eligible.

## Test plan
- Reset: hold rst_n=0 with random inputs → pix_color=0, pix_hit=0, opaque_cnt=0, rom_row=rom_col=0.
- Address mapping: pos latched (30,40), drive hcount=100, vcount=50 → rom_col=70, rom_row=10 after 1 edge; hcount=29 → rom_col=0, rom_row=0, and 3 edges later pix_color=bg_color.
- Transparency: ROM model returns 12'h000 at an in-box pixel with bg_color=12'h0F0 → pix_color=12'h0F0, pix_hit=0; ROM returns 12'hFFF → pix_color=12'hFFF, pix_hit=1, exactly 3 edges after input.
- Position latch: change pos_x 30→200 mid-frame → mapping unchanged until the next frame_start, then the new offset applies to the pixel sampled one cycle after the pulse.
- Statistics: frame of 640×480 with sprite at (0,0) over a ROM model holding 1000 opaque pixels → opaque_cnt=1000 after the next frame_start; a pix_hit coinciding with frame_start is counted in the following frame.
- Blink (SPRITE_BLINK_EN): after 32 frame_start pulses → opaque pixels show background, pix_hit=0; after 64 pulses → sprite visible again.

Source files
------------

// File: rtl/sprite_overlay.sv
// sprite_overlay: per-pixel sprite compositor with colour-key transparency.
// Three-edge pipeline: address -> ROM fetch (external, 1 cycle) -> merge.
// Sprite position is latched once per frame; opaque pixels per frame are
// counted and reported on the following frame_start.
// Optional feature macro: SPRITE_BLINK_EN (32 frames shown / 32 hidden).
module sprite_overlay #(
  parameter int          SPR_W     = 584,
  parameter int          SPR_H     = 167,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [11:0] bg_color,
  output logic [7:0]  rom_row,
  output logic [9:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic [11:0] pix_color,
  output logic        pix_hit,
  output logic [16:0] opaque_cnt
);

  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);

  logic [9:0]  x_lat, y_lat;
  logic        in_box_next;
  logic [9:0]  col_next;
  logic [7:0]  row_next;
  logic        in_box_s1, video_on_s1;
  logic [11:0] bg_s1;
  logic        in_box_s2, video_on_s2;
  logic [11:0] bg_s2;
  logic        sprite_ok;
  logic        show_sprite;
  logic [11:0] pix_color_next;
  logic        pix_hit_next;
  logic [16:0] acc;

  // Sprite position captured at frame start; mid-frame changes wait a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat <= '0;
      y_lat <= '0;
    end else if (frame_start) begin
      x_lat <= pos_x;
      y_lat <= pos_y;
    end
  end

  // Box test and sprite-relative address; 11-bit sums cannot overflow
  always_comb begin
    in_box_next = ({1'b0, hcount} >= {1'b0, x_lat}) &&
                  ({1'b0, hcount} <  ({1'b0, x_lat} + SPR_W11)) &&
                  ({1'b0, vcount} >= {1'b0, y_lat}) &&
                  ({1'b0, vcount} <  ({1'b0, y_lat} + SPR_H11));
    col_next = '0;
    row_next = '0;
    if (in_box_next) begin
      col_next = hcount - x_lat;
      // Row address only needs the low 8 bits of the difference
      row_next = vcount[7:0] - y_lat[7:0];
    end
  end

  // Stage 1: ROM address plus sideband registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_row     <= '0;
      rom_col     <= '0;
      in_box_s1   <= 1'b0;
      video_on_s1 <= 1'b0;
      bg_s1       <= '0;
    end else begin
      rom_row     <= row_next;
      rom_col     <= col_next;
      in_box_s1   <= in_box_next;
      video_on_s1 <= video_on;
      bg_s1       <= bg_color;
    end
  end

  // Stage 2: sideband delayed to line up with rom_data from the ROM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_s2   <= 1'b0;
      video_on_s2 <= 1'b0;
      bg_s2       <= '0;
    end else begin
      in_box_s2   <= in_box_s1;
      video_on_s2 <= video_on_s1;
      bg_s2       <= bg_s1;
    end
  end

`ifdef SPRITE_BLINK_EN
  logic [5:0] blink_cnt;

  // Frame counter: sprite hidden while the MSB is set (32 on / 32 off)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else if (frame_start) begin
      blink_cnt <= blink_cnt + 6'd1;
    end
  end

  assign sprite_ok = ~blink_cnt[5];
`else
  assign sprite_ok = 1'b1;
`endif

  // Stage 3 merge: blanking, then opaque sprite, else background
  always_comb begin
    show_sprite    = in_box_s2 && (rom_data != KEY_COLOR) && sprite_ok;
    pix_color_next = '0;
    pix_hit_next   = 1'b0;
    if (video_on_s2) begin
      if (show_sprite) begin
        pix_color_next = rom_data;
        pix_hit_next   = 1'b1;
      end else begin
        pix_color_next = bg_s2;
      end
    end
  end

  // Stage 3 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_color <= '0;
      pix_hit   <= 1'b0;
    end else begin
      pix_color <= pix_color_next;
      pix_hit   <= pix_hit_next;
    end
  end

  // Opaque-pixel statistics; a hit on the frame_start cycle opens the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      opaque_cnt <= '0;
    end else if (frame_start) begin
      opaque_cnt <= acc;
      acc        <= {16'd0, pix_hit};
    end else if (pix_hit && (acc != 17'h1FFFF)) begin
      acc <= acc + 17'd1;
    end
  end

endmodule
